data_mem_responder: RTL and testbench

Memory-side responder for the load/store unit's data memory interface. It accepts `memReqStruct` requests from the mem functional unit, queues them in order, and services each with a fixed access latency against an internal word-addressed array. It returns one `memRespStruct` per request, in request order, with a ready/valid handshake on both sides. It sits between the mem FU issue path and the complete stage.

---
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// In-order data memory responder: a request FIFO feeding a fixed-latency access FSM
// over a word-addressed array, with ready/valid handshakes on both request and response.
package data_mem_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wr_data;
      logic        MemWrite;
      logic        MemRead;
      logic        valid;
   } memReqStruct;

   typedef struct packed {
      logic [31:0] rd_data;
      logic        MemWrite;
      logic        MemRead;
      logic        valid;
   } memRespStruct;
endpackage

module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  memReqStruct  mem_req,
   output logic         req_ready,
   output memRespStruct mem_resp,
   input  logic         resp_ready
);
   localparam int AW   = $clog2(DEPTH_WORDS);
   localparam int QW   = $clog2(QUEUE_DEPTH);
   localparam int CNTW = QW + 1;
   localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [QW:0]   Q_FULL   = QUEUE_DEPTH[QW:0];
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
      logic          wr;
      logic          rd;
   } entry_t;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   entry_t        fifo_q [QUEUE_DEPTH];
   logic [QW-1:0] wptr_q, wptr_d;
   logic [QW-1:0] rptr_q, rptr_d;
   logic [QW:0]   count_q, count_d;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   entry_t        act_q, act_d;
   memRespStruct  resp_q, resp_d;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          push, pop, empty, full, mem_we;
   entry_t        new_entry;
   logic          unused_addr_bits;

   // Only the word index bits of the address matter; the rest alias away.
   assign unused_addr_bits = ^{mem_req.addr[31:AW+2], mem_req.addr[1:0]};

   assign new_entry = '{idx:   mem_req.addr[AW+1:2],
                        wdata: mem_req.wr_data,
                        wr:    mem_req.MemWrite,
                        rd:    mem_req.MemRead};

   assign full      = (count_q == Q_FULL);
   assign empty     = (count_q == '0);
   assign req_ready = !full;
   assign push      = mem_req.valid && !full;
   assign mem_resp  = resp_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + QW'(1);
      if (pop)  rptr_d = rptr_q + QW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      resp_d  = resp_q;
      pop     = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               act_d   = fifo_q[rptr_q];
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               resp_d.valid    = 1'b1;
               resp_d.MemWrite = act_q.wr;
               resp_d.MemRead  = act_q.rd;
               resp_d.rd_data  = '0;
               // Both flags set behaves as a write; neither flag touches nothing.
               if (act_q.wr) begin
                  mem_we = 1'b1;
               end else if (act_q.rd) begin
                  resp_d.rd_data = mem_q[act_q.idx];
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_d.valid = 1'b0;
               if (!empty) begin
                  pop     = 1'b1;
                  act_d   = fifo_q[rptr_q];
                  cnt_d   = CNT_LOAD;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         resp_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= new_entry;
      act_q <= act_d;
   end

   // Array is never cleared, but a write coinciding with reset must be suppressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n && mem_we) begin
         mem_q[act_q.idx] <= act_q.wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, backpressure, aliasing, flag corners, reset.
module tb_data_mem_responder;
   import data_mem_pkg::*;

   logic         clk;
   logic         rst_n;
   memReqStruct  mem_req;
   logic         req_ready;
   memRespStruct mem_resp;
   logic         resp_ready;

   int n_cmp;
   int n_fail;

   data_mem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY(2),
      .QUEUE_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_req(mem_req),
      .req_ready(req_ready),
      .mem_resp(mem_resp),
      .resp_ready(resp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one request and return just after the edge that accepts it.
   task automatic send(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic wr, input logic rd);
      mem_req.addr     = a;
      mem_req.wr_data  = d;
      mem_req.MemWrite = wr;
      mem_req.MemRead  = rd;
      mem_req.valid    = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (req_ready) break;
         tick();
      end
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      tick();
      mem_req.valid = 1'b0;
   endtask

   // Wait for a response, compare it, then consume it with one handshake edge.
   task automatic get_resp(input string tag, input logic [31:0] exp_data,
                           input logic exp_wr, input logic exp_rd);
      logic saved;
      for (int k = 0; k < 50; k++) begin
         if (mem_resp.valid) break;
         tick();
      end
      check({tag, "_valid"}, {31'd0, mem_resp.valid}, 32'd1);
      check({tag, "_rd_data"}, mem_resp.rd_data, exp_data);
      check({tag, "_flags"}, {30'd0, mem_resp.MemWrite, mem_resp.MemRead}, {30'd0, exp_wr, exp_rd});
      saved      = resp_ready;
      resp_ready = 1'b1;
      tick();
      resp_ready = saved;
   endtask

   task automatic wr_rd_pair(input string tag, input logic [31:0] a, input logic [31:0] d);
      resp_ready = 1'b1;
      send({tag, "_wr"}, a, d, 1'b1, 1'b0);
      check({tag, "_lat_e0"}, {31'd0, mem_resp.valid}, 32'd0);
      tick();
      tick();
      check({tag, "_lat_e2"}, {31'd0, mem_resp.valid}, 32'd0);
      tick();
      check({tag, "_lat_e3"}, {31'd0, mem_resp.valid}, 32'd1);
      get_resp({tag, "_wresp"}, 32'd0, 1'b1, 1'b0);
      send({tag, "_rd"}, a, 32'd0, 1'b0, 1'b1);
      get_resp({tag, "_rresp"}, d, 1'b0, 1'b1);
   endtask

   initial begin
      logic seen;
      n_cmp      = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      resp_ready = 1'b0;
      mem_req    = '0;
      tick();
      tick();
      check("rst_valid", {31'd0, mem_resp.valid}, 32'd0);
      check("rst_flags", {30'd0, mem_resp.MemWrite, mem_resp.MemRead}, 32'd0);
      check("rst_rd_data", mem_resp.rd_data, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      #3 rst_n = 1'b1;
      tick();

      // Write then read with three-cycle response latency
      wr_rd_pair("t1", 32'h10, 32'hDEADBEEF);

      // Backpressure fill: five accepted, sixth stalls
      resp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mem_req.addr     = 32'(i * 4);
         mem_req.wr_data  = 32'h100 + 32'(i);
         mem_req.MemWrite = 1'b1;
         mem_req.MemRead  = 1'b0;
         mem_req.valid    = 1'b1;
         check("bp_accept_ready", {31'd0, req_ready}, 32'd1);
         tick();
      end
      mem_req.addr    = 32'h14;
      mem_req.wr_data = 32'h105;
      check("bp_full_ready", {31'd0, req_ready}, 32'd0);
      check("bp_first_valid", {31'd0, mem_resp.valid}, 32'd1);
      check("bp_first_flags", {30'd0, mem_resp.MemWrite, mem_resp.MemRead}, 32'd2);
      tick();
      tick();
      check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, mem_resp.valid}, 32'd1);
      check("bp_hold_rd_data", mem_resp.rd_data, 32'd0);
      resp_ready = 1'b1;
      tick();
      check("bp_ready_rise", {31'd0, req_ready}, 32'd1);
      check("bp_valid_drop", {31'd0, mem_resp.valid}, 32'd0);
      tick();
      mem_req.valid = 1'b0;
      for (int i = 0; i < 5; i++) get_resp("bp_resp", 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         send("bp_rd", 32'(i * 4), 32'd0, 1'b0, 1'b1);
         get_resp("bp_rdback", 32'h100 + 32'(i), 1'b0, 1'b1);
      end

      // Aliasing: high address bits and byte offset are ignored
      send("al_wr", 32'h404, 32'h12345678, 1'b1, 1'b0);
      get_resp("al_wresp", 32'd0, 1'b1, 1'b0);
      send("al_rd4", 32'h004, 32'd0, 1'b0, 1'b1);
      get_resp("al_rd4_resp", 32'h12345678, 1'b0, 1'b1);
      send("al_rd7", 32'h007, 32'd0, 1'b0, 1'b1);
      get_resp("al_rd7_resp", 32'h12345678, 1'b0, 1'b1);

      // Flag corners: neither flag, both flags, then read back
      send("fl_none", 32'h10, 32'h0, 1'b0, 1'b0);
      get_resp("fl_none_resp", 32'd0, 1'b0, 1'b0);
      send("fl_both", 32'h20, 32'hA5, 1'b1, 1'b1);
      get_resp("fl_both_resp", 32'd0, 1'b1, 1'b1);
      send("fl_rd20", 32'h20, 32'd0, 1'b0, 1'b1);
      get_resp("fl_rd20_resp", 32'hA5, 1'b0, 1'b1);
      send("fl_rd10", 32'h10, 32'd0, 1'b0, 1'b1);
      get_resp("fl_rd10_resp", 32'h104, 1'b0, 1'b1);

      // Reset while busy: queued and active requests vanish
      resp_ready = 1'b1;
      send("rs_q0", 32'h0, 32'd0, 1'b0, 1'b1);
      send("rs_q1", 32'h4, 32'd0, 1'b0, 1'b1);
      send("rs_q2", 32'h8, 32'd0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rs_async_valid", {31'd0, mem_resp.valid}, 32'd0);
      check("rs_async_ready", {31'd0, req_ready}, 32'd1);
      tick();
      tick();
      #3 rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (mem_resp.valid) seen = 1'b1;
      end
      check("rs_no_resp", {31'd0, seen}, 32'd0);
      wr_rd_pair("rs_pair", 32'h10, 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
